// File: rtl/loader_pkg.sv
// Shared types and constants for the serial program loader.
package loader_pkg;

    localparam int MEM_DEPTH = 256;
    localparam int ADR_W     = 8;
    localparam int BYTE_W    = 8;
    // One extra bit so a length byte of zero can mean a full 256-byte image.
    localparam int CNT_W     = ADR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_t;

    // Length byte to data-byte count: 0 encodes MEM_DEPTH bytes.
    function automatic logic [CNT_W-1:0] len_decode(input logic [BYTE_W-1:0] n);
        return (n == '0) ? CNT_W'(MEM_DEPTH) : {1'b0, n};
    endfunction

endpackage

// File: rtl/loader_csum.sv
// Running 8-bit modular checksum over the accepted stream bytes.
module loader_csum
    import loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [BYTE_W-1:0] sum,
    output logic              zero
);

    logic [BYTE_W-1:0] sum_with_byte;

    // Sum as it would be after adding the byte currently presented.
    assign sum_with_byte = sum + byte_in;

    // Flags a good checksum: true when the presented byte brings the total to zero.
    assign zero = (sum_with_byte == '0);

    // Accumulate every accepted byte; clear at the start of each load.
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (enable) begin
            sum <= sum_with_byte;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed, checksummed program image into memory while
// holding the CPU datapath frozen until a good image has been written.
module program_loader
    import loader_pkg::*;
#(
    parameter logic [ADR_W-1:0] BASE_ADR = 8'h00
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_byte,
    output logic              in_ready,
    output logic [ADR_W-1:0]  mem_adr,
    output logic [BYTE_W-1:0] mem_wd,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  data_cnt;
    logic [CNT_W-1:0]  data_len;
    logic              accept;
    logic              data_accept;
    logic              last_data;
    logic              load_start;
    logic              csum_zero;
    // Running sum is exposed by the checksum block for debug; only its zero flag steers the FSM.
    logic [BYTE_W-1:0] csum_unused;

    assign in_ready    = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
    assign accept      = in_valid && in_ready;
    assign data_accept = accept && (state == ST_DATA);
    assign last_data   = (data_cnt == (data_len - CNT_W'(1)));

    loader_csum u_csum (
        .clock   (clock),
        .reset   (reset),
        .clear   (load_start),
        .enable  (accept),
        .byte_in (in_byte),
        .sum     (csum_unused),
        .zero    (csum_zero)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only honoured between loads.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        load_start = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_next = ST_LEN;
                    load_start = 1'b1;
                end
            end
            ST_LEN: begin
                if (accept) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (accept && last_data) state_next = ST_CSUM;
            end
            ST_CSUM: begin
                if (accept) state_next = csum_zero ? ST_DONE : ST_ERROR;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Data-byte index and decoded image length.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_cnt <= '0;
            data_len <= '0;
        end else begin
            if (load_start) begin
                data_cnt <= '0;
            end else if (data_accept) begin
                data_cnt <= data_cnt + CNT_W'(1);
            end
            if (accept && (state == ST_LEN)) begin
                data_len <= len_decode(in_byte);
            end
        end
    end

    // Registered memory write port; address and data hold between writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_adr <= BASE_ADR;
            mem_wd  <= '0;
            mem_we  <= 1'b0;
        end else begin
            mem_we <= data_accept;
            if (data_accept) begin
                mem_adr <= BASE_ADR + data_cnt[ADR_W-1:0];
                mem_wd  <= in_byte;
            end
        end
    end

    // Registered status outputs, decoded from the state being entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            cpu_hold <= (state_next != ST_DONE);
            done     <= (state_next == ST_DONE);
            err      <= (state_next == ST_ERROR);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench: two loaders (base 00 and base FE) share one stream;
// memory writes are checked against a per-instance scoreboard queue.
module tb_program_loader;

    localparam int CS_GOOD  = 0;
    localparam int CS_PLUS1 = 1;
    localparam int CS_FIXED = 2;

    typedef struct {
        logic [7:0] len;
        logic [7:0] seed;
        logic [7:0] step;
        int         cs_mode;
        logic [7:0] cs_fixed;
        logic       gaps;
        logic       exp_done;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic [7:0] adr;
        logic [7:0] wd;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] in_byte;

    logic       in_ready0, mem_we0, cpu_hold0, done0, err0;
    logic [7:0] mem_adr0, mem_wd0;
    logic       in_ready1, mem_we1, cpu_hold1, done1, err1;
    logic [7:0] mem_adr1, mem_wd1;

    int checks = 0;
    int errors = 0;
    int writes0 = 0;
    int writes1 = 0;
    wr_t q0[$];
    wr_t q1[$];
    vec_t vecs[7];
    vec_t v_abort;

    always #5 clk = ~clk;

    program_loader #(.BASE_ADR(8'h00)) dut0 (
        .clock(clk), .reset(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready0), .mem_adr(mem_adr0), .mem_wd(mem_wd0), .mem_we(mem_we0),
        .cpu_hold(cpu_hold0), .done(done0), .err(err0)
    );

    program_loader #(.BASE_ADR(8'hFE)) dut1 (
        .clock(clk), .reset(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready1), .mem_adr(mem_adr1), .mem_wd(mem_wd1), .mem_we(mem_we1),
        .cpu_hold(cpu_hold1), .done(done1), .err(err1)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Scoreboard side: every write strobe must match the oldest queued entry.
    always @(negedge clk) begin
        if (mem_we0) begin
            writes0++;
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write dut0 adr=%0h wd=%0h expected=none", mem_adr0, mem_wd0);
            end else begin
                wr_t e;
                e = q0.pop_front();
                check("dut0_adr", mem_adr0, e.adr);
                check("dut0_wd", mem_wd0, e.wd);
            end
        end
        if (mem_we1) begin
            writes1++;
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write dut1 adr=%0h wd=%0h expected=none", mem_adr1, mem_wd1);
            end else begin
                wr_t e;
                e = q1.pop_front();
                check("dut1_adr", mem_adr1, e.adr);
                check("dut1_wd", mem_wd1, e.wd);
            end
        end
    end

    // Present one byte from a negedge, wait (bounded) for in_ready, return at the
    // negedge after acceptance. Data bytes push their expected writes.
    task automatic send_byte(input logic [7:0] b, input logic is_data, input int k);
        int   waited;
        wr_t  e;
        logic [7:0] kk;
        waited   = 0;
        in_valid = 1'b1;
        in_byte  = b;
        while (!in_ready0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready0) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout actual=0 expected=1");
        end else if (is_data) begin
            kk = 8'(k);
            e.adr = 8'h00 + kk; e.wd = b; q0.push_back(e);
            e.adr = 8'hFE + kk; e.wd = b; q1.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_load(input vec_t v, input int abort_after);
        logic [7:0] d;
        logic [7:0] sum;
        logic [7:0] cs;
        int         nb;
        nb = (v.len == 8'h00) ? 256 : int'(v.len);
        writes0 = 0;
        writes1 = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_ready", in_ready0, 1);
        check("start_done", done0, 0);
        check("start_err", err0, 0);
        check("start_hold", cpu_hold0, 1);
        sum = v.len;
        send_byte(v.len, 1'b0, 0);
        d = v.seed;
        for (int k = 0; k < nb; k++) begin
            if (v.gaps) begin
                in_valid = 1'b0;
                if (k == 2) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(d, 1'b1, k);
            sum = sum + d;
            d   = d + v.step;
            if (abort_after == k + 1) begin
                @(posedge clk);
                #1 rst = 1'b1;
                in_valid = 1'b1;
                in_byte  = 8'h5A;
                repeat (3) @(negedge clk);
                check("abort_mem_we", mem_we0, 0);
                check("abort_in_ready", in_ready0, 0);
                check("abort_hold", cpu_hold0, 1);
                check("abort_adr1", mem_adr1, 8'hFE);
                check("abort_wd0", mem_wd0, 8'h00);
                rst = 1'b0;
                repeat (3) @(negedge clk);
                check("idle_after_abort_in_ready", in_ready0, 0);
                check("idle_after_abort_hold", cpu_hold0, 1);
                check("abort_write_count", writes0, abort_after);
                check("abort_queue_empty", q0.size(), 0);
                in_valid = 1'b0;
                return;
            end
        end
        if (v.gaps) begin
            in_valid = 1'b0;
            start    = 1'b1;
            @(negedge clk);
            start    = 1'b0;
        end
        case (v.cs_mode)
            CS_GOOD:  cs = 8'h00 - sum;
            CS_PLUS1: cs = 8'h01 - sum;
            default:  cs = v.cs_fixed;
        endcase
        check("hold_before_csum", cpu_hold0, 1);
        send_byte(cs, 1'b0, 0);
        check("end_done0", done0, v.exp_done);
        check("end_err0", err0, v.exp_err);
        check("end_done1", done1, v.exp_done);
        check("end_hold", cpu_hold0, !v.exp_done);
        check("end_mem_we", mem_we0, 0);
        check("end_queue0_empty", q0.size(), 0);
        check("end_queue1_empty", q1.size(), 0);
        check("write_count0", writes0, nb);
        check("write_count1", writes1, nb);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_adr0", mem_adr0, 8'h00);
        check("rst_adr1", mem_adr1, 8'hFE);
        check("rst_wd", mem_wd0, 8'h00);
        check("rst_we", mem_we0, 0);
        check("rst_hold", cpu_hold0, 1);
        check("rst_done", done0, 0);
        check("rst_err", err0, 0);
        check("rst_in_ready", in_ready0, 0);
        rst = 1'b0;

        // IDLE must not consume bytes without a start.
        in_valid = 1'b1;
        in_byte  = 8'h77;
        repeat (3) @(negedge clk);
        check("idle_in_ready", in_ready0, 0);
        check("idle_no_writes", writes0, 0);
        in_valid = 1'b0;

        //          len    seed   step   cs_mode   cs_fixed gaps  done  err
        vecs[0] = '{8'h04, 8'h11, 8'h11, CS_GOOD,  8'h00, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h03, 8'hAA, 8'h11, CS_GOOD,  8'h00, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h02, 8'h01, 8'h01, CS_FIXED, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h01, 8'h05, 8'h00, CS_GOOD,  8'h00, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h06, 8'h3C, 8'h07, CS_GOOD,  8'h00, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h05, 8'h80, 8'h33, CS_PLUS1, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 8'h01, CS_GOOD,  8'h00, 1'b0, 1'b1, 1'b0};
        v_abort = '{8'h00, 8'h40, 8'h01, CS_GOOD,  8'h00, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < 7; i++) begin
            run_load(vecs[i], 0);
        end

        // Full-length rerun cut short by reset, then a normal load to show recovery.
        run_load(v_abort, 10);
        run_load(vecs[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
